// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the 640x480@60 video path.
package vga_pkg;

  localparam int unsigned COUNT_W     = 10;
  localparam int unsigned CMP_W       = 11;
  localparam int unsigned VIDEO_W_DEF = 3;

  localparam int unsigned TOTAL_COLS_DEF       = 800;
  localparam int unsigned TOTAL_ROWS_DEF       = 525;
  localparam int unsigned ACTIVE_COLS_DEF      = 640;
  localparam int unsigned ACTIVE_ROWS_DEF      = 480;
  localparam int unsigned FRONT_PORCH_HORZ_DEF = 18;
  localparam int unsigned BACK_PORCH_HORZ_DEF  = 50;
  localparam int unsigned FRONT_PORCH_VERT_DEF = 10;
  localparam int unsigned BACK_PORCH_VERT_DEF  = 33;

  // Half-open window test lo <= val < hi, widened so porch sums cannot wrap.
  function automatic logic in_window(input logic [CMP_W-1:0] val,
                                     input logic [CMP_W-1:0] lo,
                                     input logic [CMP_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_porch_if.sv
// Upstream pattern-generator signals in, board VGA pins out.
interface vga_sync_porch_if
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = VIDEO_W_DEF
);

  logic                   i_HSync;
  logic                   i_VSync;
  logic [VIDEO_WIDTH-1:0] i_Red_Video;
  logic [VIDEO_WIDTH-1:0] i_Grn_Video;
  logic [VIDEO_WIDTH-1:0] i_Blu_Video;

  logic                   o_HSync;
  logic                   o_VSync;
  logic [VIDEO_WIDTH-1:0] o_Red_Video;
  logic [VIDEO_WIDTH-1:0] o_Grn_Video;
  logic [VIDEO_WIDTH-1:0] o_Blu_Video;

  modport master (
    output i_HSync, i_VSync, i_Red_Video, i_Grn_Video, i_Blu_Video,
    input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video
  );

  modport slave (
    input  i_HSync, i_VSync, i_Red_Video, i_Grn_Video, i_Blu_Video,
    output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video
  );

endinterface

// File: rtl/vga_frame_counter.sv
// Frame-start detect on the i_VSync rising edge, col/row position counters and
// a sticky lock flag that says the counters are aligned to the upstream frame.
module vga_frame_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS = TOTAL_COLS_DEF,
  parameter int unsigned TOTAL_ROWS = TOTAL_ROWS_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_VSync,
  output logic [COUNT_W-1:0] o_Col,
  output logic [COUNT_W-1:0] o_Row,
  output logic               o_Locked
);

  logic               r_VSync_Prev;
  logic               r_Locked;
  logic [COUNT_W-1:0] r_Col;
  logic [COUNT_W-1:0] r_Row;
  logic               frame_start_c;
  logic               col_last_c;
  logic               row_last_c;

  assign frame_start_c = i_VSync & ~r_VSync_Prev;
  assign col_last_c    = (r_Col == COUNT_W'(TOTAL_COLS - 1));
  assign row_last_c    = (r_Row == COUNT_W'(TOTAL_ROWS - 1));

  // A frame start always wins over the free-running wrap, so a mid-frame
  // resync snaps the position back to the origin in a single cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_VSync_Prev <= 1'b0;
      r_Locked     <= 1'b0;
      r_Col        <= '0;
      r_Row        <= '0;
    end else begin
      r_VSync_Prev <= i_VSync;
      if (frame_start_c) begin
        r_Locked <= 1'b1;
        r_Col    <= '0;
        r_Row    <= '0;
      end else if (col_last_c) begin
        r_Col <= '0;
        r_Row <= row_last_c ? '0 : r_Row + COUNT_W'(1);
      end else begin
        r_Col <= r_Col + COUNT_W'(1);
      end
    end
  end

  assign o_Col    = r_Col;
  assign o_Row    = r_Row;
  assign o_Locked = r_Locked;

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: regenerates porch-framed sync pulses from the upstream
// active-region flags and blanks video, with two-cycle matched latency.
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH      = VIDEO_W_DEF,
  parameter int unsigned TOTAL_COLS       = TOTAL_COLS_DEF,
  parameter int unsigned TOTAL_ROWS       = TOTAL_ROWS_DEF,
  parameter int unsigned ACTIVE_COLS      = ACTIVE_COLS_DEF,
  parameter int unsigned ACTIVE_ROWS      = ACTIVE_ROWS_DEF,
  parameter int unsigned FRONT_PORCH_HORZ = FRONT_PORCH_HORZ_DEF,
  parameter int unsigned BACK_PORCH_HORZ  = BACK_PORCH_HORZ_DEF,
  parameter int unsigned FRONT_PORCH_VERT = FRONT_PORCH_VERT_DEF,
  parameter int unsigned BACK_PORCH_VERT  = BACK_PORCH_VERT_DEF
) (
  input  logic            i_Clk,
  input  logic            i_Rst_L,
  vga_sync_porch_if.slave vga
);

  localparam logic [CMP_W-1:0] H_PULSE_LO = CMP_W'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [CMP_W-1:0] H_PULSE_HI = CMP_W'(TOTAL_COLS - BACK_PORCH_HORZ);
  localparam logic [CMP_W-1:0] V_PULSE_LO = CMP_W'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [CMP_W-1:0] V_PULSE_HI = CMP_W'(TOTAL_ROWS - BACK_PORCH_VERT);
  localparam logic [CMP_W-1:0] H_ACTIVE   = CMP_W'(ACTIVE_COLS);
  localparam logic [CMP_W-1:0] V_ACTIVE   = CMP_W'(ACTIVE_ROWS);

  logic [COUNT_W-1:0]     fc_col;
  logic [COUNT_W-1:0]     fc_row;
  logic                   fc_locked;

  logic [VIDEO_WIDTH-1:0] r_Red_S0, r_Grn_S0, r_Blu_S0;
  logic [VIDEO_WIDTH-1:0] r_Red_S1, r_Grn_S1, r_Blu_S1;
  logic [COUNT_W-1:0]     r_Col_S1;
  logic [COUNT_W-1:0]     r_Row_S1;
  logic                   r_Locked_S1;

  logic                   r_HSync;
  logic                   r_VSync;
  logic [VIDEO_WIDTH-1:0] r_Red, r_Grn, r_Blu;

  logic                   h_pulse_c;
  logic                   v_pulse_c;
  logic                   active_c;
  logic                   unused_hsync_c;

  // Upstream column alignment is carried entirely by i_VSync.
  assign unused_hsync_c = vga.i_HSync;

  vga_frame_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_frame_counter (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_VSync  (vga.i_VSync),
    .o_Col    (fc_col),
    .o_Row    (fc_row),
    .o_Locked (fc_locked)
  );

  // The counter value after edge t names the sample captured at t, so the
  // video is registered once here to stay aligned with it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Red_S0    <= '0;
      r_Grn_S0    <= '0;
      r_Blu_S0    <= '0;
      r_Red_S1    <= '0;
      r_Grn_S1    <= '0;
      r_Blu_S1    <= '0;
      r_Col_S1    <= '0;
      r_Row_S1    <= '0;
      r_Locked_S1 <= 1'b0;
    end else begin
      r_Red_S0    <= vga.i_Red_Video;
      r_Grn_S0    <= vga.i_Grn_Video;
      r_Blu_S0    <= vga.i_Blu_Video;
      r_Red_S1    <= r_Red_S0;
      r_Grn_S1    <= r_Grn_S0;
      r_Blu_S1    <= r_Blu_S0;
      r_Col_S1    <= fc_col;
      r_Row_S1    <= fc_row;
      r_Locked_S1 <= fc_locked;
    end
  end

  always_comb begin
    h_pulse_c = in_window(CMP_W'(r_Col_S1), H_PULSE_LO, H_PULSE_HI);
    v_pulse_c = in_window(CMP_W'(r_Row_S1), V_PULSE_LO, V_PULSE_HI);
    active_c  = (CMP_W'(r_Col_S1) < H_ACTIVE) && (CMP_W'(r_Row_S1) < V_ACTIVE);
  end

  // Hold the pins idle until the counters have seen a frame start.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_HSync <= 1'b1;
      r_VSync <= 1'b1;
      r_Red   <= '0;
      r_Grn   <= '0;
      r_Blu   <= '0;
    end else if (!r_Locked_S1) begin
      r_HSync <= 1'b1;
      r_VSync <= 1'b1;
      r_Red   <= '0;
      r_Grn   <= '0;
      r_Blu   <= '0;
    end else begin
      r_HSync <= ~h_pulse_c;
      r_VSync <= ~v_pulse_c;
      r_Red   <= active_c ? r_Red_S1 : '0;
      r_Grn   <= active_c ? r_Grn_S1 : '0;
      r_Blu   <= active_c ? r_Blu_S1 : '0;
    end
  end

  assign vga.o_HSync     = r_HSync;
  assign vga.o_VSync     = r_VSync;
  assign vga.o_Red_Video = r_Red;
  assign vga.o_Grn_Video = r_Grn;
  assign vga.o_Blu_Video = r_Blu;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Self-checking bench for vga_sync_porch: upstream pattern generator plus a
// frame-position reference model built from elapsed clocks since frame start.
module tb_vga_sync_porch;

  // Full horizontal timing; vertical shortened to keep whole frames cheap.
  localparam int TC = 800, TR = 41, AC = 640, AR = 34;
  localparam int FPH = 18, BPH = 50, FPV = 2, BPV = 3, VW = 3;
  localparam int OW = 2 + 3 * VW;
  localparam logic [OW-1:0] IDLE = {2'b11, {(3 * VW){1'b0}}};
  localparam int MODE_RED = 0, MODE_RAND = 1, MODE_CHK = 2;

  typedef struct {
    logic [OW-1:0] exp;
    int            col;
    int            row;
    bit            lk;
    bit            fs;
    bit            rs;
    bit            chk;
    bit            red;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_sync_porch_if #(.VIDEO_WIDTH(VW)) vif ();

  vga_sync_porch #(
    .VIDEO_WIDTH      (VW),
    .TOTAL_COLS       (TC),
    .TOTAL_ROWS       (TR),
    .ACTIVE_COLS      (AC),
    .ACTIVE_ROWS      (AR),
    .FRONT_PORCH_HORZ (FPH),
    .BACK_PORCH_HORZ  (BPH),
    .FRONT_PORCH_VERT (FPV),
    .BACK_PORCH_VERT  (BPV)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .vga     (vif)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  int up_col, up_row, mode;
  bit force_low, rs_mark;
  bit m_prev, m_locked;
  int m_since;

  int out_idx, start_idx, hfall_prev, hlow_start, vfall_prev, vlow_start;
  bit start_pend, prev_hs, prev_vs;

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pins();
    return {vif.o_HSync, vif.o_VSync, vif.o_Red_Video, vif.o_Grn_Video, vif.o_Blu_Video};
  endfunction

  task automatic drive();
    logic [VW-1:0] r, g, b;
    bit c;
    c = (((up_col >> 5) ^ (up_row >> 5)) & 1) != 0;
    case (mode)
      MODE_RED: begin r = VW'(7); g = '0; b = '0; end
      MODE_CHK: begin r = c ? '1 : '0; g = r; b = r; end
      default:  begin r = VW'($urandom); g = VW'($urandom); b = VW'($urandom); end
    endcase
    vif.i_HSync     = (up_col < AC);
    vif.i_VSync     = (up_row < AR) && !force_low;
    vif.i_Red_Video = r;
    vif.i_Grn_Video = g;
    vif.i_Blu_Video = b;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    drive();
  endtask

  // Reference: screen position is simply clocks elapsed since the last
  // i_VSync rise, folded into line and frame.
  task automatic model_push();
    exp_t e;
    bit   vs, hs_o, vs_o, act;
    vs     = vif.i_VSync;
    e.fs   = vs && !m_prev;
    m_prev = vs;
    if (e.fs) begin
      m_since  = 0;
      m_locked = 1'b1;
    end else begin
      m_since++;
    end
    e.col   = m_since % TC;
    e.row   = (m_since / TC) % TR;
    e.lk    = m_locked;
    e.rs    = rs_mark;
    rs_mark = 1'b0;
    e.chk   = (mode == MODE_CHK);
    e.red   = (mode == MODE_RED);
    if (!m_locked) begin
      e.exp = IDLE;
    end else begin
      hs_o  = !(e.col >= AC + FPH && e.col < TC - BPH);
      vs_o  = !(e.row >= AR + FPV && e.row < TR - BPV);
      act   = (e.col < AC) && (e.row < AR);
      e.exp = {hs_o, vs_o,
               act ? vif.i_Red_Video : VW'(0),
               act ? vif.i_Grn_Video : VW'(0),
               act ? vif.i_Blu_Video : VW'(0)};
    end
    q.push_back(e);
  endtask

  task automatic check_out(input exp_t e);
    logic [OW-1:0] obs;
    bit hs, vs;
    int red, cexp;
    obs = pins();
    vectors++;
    assert (obs === e.exp)
    else begin
      miscompares++;
      $error("FAIL pixel col=%0d row=%0d: observed %h, expected %h", e.col, e.row, obs, e.exp);
    end
    out_idx++;
    hs  = obs[OW-1];
    vs  = obs[OW-2];
    red = int'(vif.o_Red_Video);
    if (e.fs && e.lk) begin
      start_idx  = out_idx;
      start_pend = 1'b1;
      hfall_prev = -1;
    end
    if (e.rs) vfall_prev = -1;
    if (prev_hs && !hs) begin
      if (start_pend) check_int("hsync_fall_after_start", out_idx - start_idx, 658);
      start_pend = 1'b0;
      if (hfall_prev >= 0) check_int("line_period", out_idx - hfall_prev, 800);
      hfall_prev = out_idx;
      hlow_start = out_idx;
    end
    if (!prev_hs && hs && hlow_start >= 0) begin
      check_int("hsync_width", out_idx - hlow_start, 92);
      hlow_start = -1;
    end
    if (prev_vs && !vs) begin
      if (vfall_prev >= 0) check_int("frame_period", out_idx - vfall_prev, TC * TR);
      vfall_prev = out_idx;
      vlow_start = out_idx;
    end
    if (!prev_vs && vs && vlow_start >= 0) begin
      check_int("vsync_width", out_idx - vlow_start, 2 * TC);
      vlow_start = -1;
    end
    if (e.lk && e.red && e.row == 0 && (e.col == 0 || e.col == AC - 1))
      check_int("red_first_line", red, 7);
    if (e.lk && e.red && e.row == 0 && e.col == AC)
      check_int("red_blank_after", red, 0);
    if (e.lk && e.chk && ((e.col == 0 && e.row == 0) || (e.col == 32 && e.row == 0) ||
                          (e.col == 0 && e.row == 32) || (e.col == AC - 1 && e.row == AR - 1))) begin
      cexp = ((((e.col >> 5) ^ (e.row >> 5)) & 1) != 0) ? 7 : 0;
      check_int("checker_pixel", red, cexp);
    end
    prev_hs = hs;
    prev_vs = vs;
  endtask

  task automatic step();
    model_push();
    @(posedge clk);
    #1;
    if (q.size() > 2) check_out(q.pop_front());
    up_col++;
    if (up_col == TC) begin
      up_col = 0;
      up_row = (up_row + 1) % TR;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int row, input int col);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 50000 && !hit; i++) begin
      step();
      hit = (up_row == row) && (up_col == col);
    end
    if (!hit) check_int("run_until_timeout", up_row * TC + up_col, row * TC + col);
  endtask

  // Called mid-cycle: async reset must idle the pins with no clock edge.
  task automatic reset_dut(input int start_row);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    assert (pins() === IDLE)
    else begin
      miscompares++;
      $error("FAIL async_reset_idle: observed %h, expected %h", pins(), IDLE);
    end
    repeat (2) @(posedge clk);
    up_row = start_row;
    up_col = 0;
    drive();
    m_prev   = 1'b0;
    m_locked = 1'b0;
    m_since  = 0;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.exp = IDLE; e.col = 0; e.row = 0;
      e.lk = 0; e.fs = 0; e.rs = 0; e.chk = 0; e.red = 0;
      q.push_back(e);
    end
    out_idx    = 0;
    start_pend = 1'b0;
    hfall_prev = -1;
    hlow_start = -1;
    vfall_prev = -1;
    vlow_start = -1;
    prev_hs    = 1'b1;
    prev_vs    = 1'b1;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    up_col = 0; up_row = 0; mode = MODE_RED;
    force_low = 1'b0; rs_mark = 1'b0;
    drive();

    // Release in vertical blanking; idle until the next i_VSync rise.
    reset_dut(39);
    set_mode(MODE_RED);
    run_until(16, 0);
    set_mode(MODE_RAND);
    run_until(0, 0);
    set_mode(MODE_CHK);
    run_until(0, 0);
    set_mode(MODE_RAND);
    run_until(10, 299);

    // Resync: a fresh i_VSync rise at col 300, row 10.
    force_low = 1'b1;
    drive();
    step();
    force_low = 1'b0;
    up_col    = 0;
    up_row    = 0;
    rs_mark   = 1'b1;
    drive();
    run(2 * TC);

    // Mid-stream reset, release in blanking, then relock.
    reset_dut(38);
    run(60);
    run_until(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
